// File: rtl/intmul_nonstd_bba_x_bba.sv
// Pipelined unsigned multiplier C = A * B. Operands split into 17/17/26-bit limbs to match
// DSP port widths; the nine limb products are reduced by a 3:2 CSA tree or a plain adder.
module intmul_nonstd_bba_x_bba #(
  parameter int LOGA     = 60,
  parameter int LOGB     = 60,
  parameter int FF_IN    = 1,
  parameter int FF_MUL   = 1,
  parameter int FF_OUT   = 1,
  parameter int USE_CSA  = 1,
  parameter int FF_CSA   = 1,
  parameter int MORE_DSP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LOGA-1:0]      A,
  input  logic [LOGB-1:0]      B,
  output logic [LOGA+LOGB-1:0] C
);
  localparam int W   = LOGA + LOGB;
  localparam int LAT = FF_IN + FF_MUL + ((USE_CSA != 0) ? FF_CSA : 0) + FF_OUT;

  if (LOGA < 35 || LOGA > 60 || LOGB < 35 || LOGB > 60 || LAT > 4) begin : g_bad_param
    $error("intmul_nonstd_bba_x_bba: illegal parameter set");
  end

  // With MORE_DSP=0 the 26-bit limbs are split at bit 17 so only 17x17 pieces need a DSP.
  function automatic logic [51:0] limb_mul(input logic [25:0] x, input logic [25:0] y);
    logic [51:0] p;
    if (MORE_DSP != 0) p = 52'(x) * 52'(y);
    else p = 52'(x[16:0]) * 52'(y[16:0])
           + ((52'(x[25:17]) * 52'(y[16:0])) << 17)
           + ((52'(x[16:0]) * 52'(y[25:17])) << 17)
           + ((52'(x[25:17]) * 52'(y[25:17])) << 34);
    return p;
  endfunction

  function automatic logic [W-1:0] csa_sum(input logic [W-1:0] a, b, c);
    return a ^ b ^ c;
  endfunction

  function automatic logic [W-1:0] csa_carry(input logic [W-1:0] a, b, c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  logic [LOGA-1:0] a_s;
  logic [LOGB-1:0] b_s;

  if (FF_IN != 0) begin : g_ff_in
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        a_s <= '0;
        b_s <= '0;
      end else begin
        a_s <= A;
        b_s <= B;
      end
    end
  end else begin : g_no_ff_in
    assign a_s = A;
    assign b_s = B;
  end

  logic [25:0] al [3];
  logic [25:0] bl [3];
  assign al[0] = 26'(a_s[16:0]);
  assign al[1] = 26'(a_s[33:17]);
  assign al[2] = 26'(a_s[LOGA-1:34]);
  assign bl[0] = 26'(b_s[16:0]);
  assign bl[1] = 26'(b_s[33:17]);
  assign bl[2] = 26'(b_s[LOGB-1:34]);

  logic [51:0] prod_d [9];
  logic [51:0] prod_s [9];

  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        prod_d[3*i+j] = limb_mul(al[i], bl[j]);
  end

  if (FF_MUL != 0) begin : g_ff_mul
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < 9; k++) prod_s[k] <= '0;
      end else begin
        for (int k = 0; k < 9; k++) prod_s[k] <= prod_d[k];
      end
    end
  end else begin : g_no_ff_mul
    always_comb begin
      for (int k = 0; k < 9; k++) prod_s[k] = prod_d[k];
    end
  end

  // Each weighted term is bounded by A*B, so W bits hold it without loss.
  logic [W-1:0] pp [9];
  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        pp[3*i+j] = W'(prod_s[3*i+j]) << (17 * (i + j));
  end

  logic [W-1:0] red_s;
  logic [W-1:0] red_c;

  if (USE_CSA != 0) begin : g_csa
    logic [W-1:0] ts [7];
    logic [W-1:0] tc [7];
    logic [W-1:0] red_s_d;
    logic [W-1:0] red_c_d;
    // 9 -> 6 -> 4 -> 3 -> 2 operands; carries past bit W-1 are always zero in the true sum.
    assign ts[0] = csa_sum(pp[0], pp[1], pp[2]);  assign tc[0] = csa_carry(pp[0], pp[1], pp[2]);
    assign ts[1] = csa_sum(pp[3], pp[4], pp[5]);  assign tc[1] = csa_carry(pp[3], pp[4], pp[5]);
    assign ts[2] = csa_sum(pp[6], pp[7], pp[8]);  assign tc[2] = csa_carry(pp[6], pp[7], pp[8]);
    assign ts[3] = csa_sum(ts[0], tc[0], ts[1]);  assign tc[3] = csa_carry(ts[0], tc[0], ts[1]);
    assign ts[4] = csa_sum(tc[1], ts[2], tc[2]);  assign tc[4] = csa_carry(tc[1], ts[2], tc[2]);
    assign ts[5] = csa_sum(ts[3], tc[3], ts[4]);  assign tc[5] = csa_carry(ts[3], tc[3], ts[4]);
    assign ts[6] = csa_sum(ts[5], tc[5], tc[4]);  assign tc[6] = csa_carry(ts[5], tc[5], tc[4]);
    assign red_s_d = ts[6];
    assign red_c_d = tc[6];

    if (FF_CSA != 0) begin : g_ff_csa
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          red_s <= '0;
          red_c <= '0;
        end else begin
          red_s <= red_s_d;
          red_c <= red_c_d;
        end
      end
    end else begin : g_no_ff_csa
      assign red_s = red_s_d;
      assign red_c = red_c_d;
    end
  end else begin : g_adder
    assign red_s = pp[0] + pp[1] + pp[2] + pp[3] + pp[4] + pp[5] + pp[6] + pp[7] + pp[8];
    assign red_c = '0;
  end

  logic [W-1:0] c_d;
  assign c_d = red_s + red_c;

  if (FF_OUT != 0) begin : g_ff_out
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) C <= '0;
      else      C <= c_d;
    end
  end else begin : g_no_ff_out
    assign C = c_d;
  end

endmodule

// File: tb/tb_intmul_nonstd_bba_x_bba.sv
// Directed bench for intmul_nonstd_bba_x_bba at default parameters: hand-computed products
// checked LAT edges after issue, plus reset behaviour.
module tb_intmul_nonstd_bba_x_bba;
  localparam int LAT = 4;
  localparam logic [59:0] ONES = {60{1'b1}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [59:0]  A = '0;
  logic [59:0]  B = '0;
  logic [119:0] C;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [119:0] exp_q[$];
  int           due_q[$];
  string        tag_q[$];

  intmul_nonstd_bba_x_bba dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .C   (C)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [119:0] got, input logic [119:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Operands set just after edge n are sampled at edge n+1 and appear after edge n+LAT.
  task automatic drive(input string tag, input logic [59:0] a, input logic [59:0] b,
                       input logic [119:0] e);
    @(posedge clk);
    #1;
    A = a;
    B = b;
    exp_q.push_back(e);
    due_q.push_back(cyc + LAT);
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    if (rst && due_q.size() > 0 && due_q[0] == cyc) begin
      check(tag_q[0], C, exp_q[0]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
      void'(tag_q.pop_front());
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    check("drain_empty", 120'(exp_q.size()), 120'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_c", C, 120'd0);
    check("lat_param", 120'(dut.LAT), 120'(LAT));
    rst = 1'b1;

    drive("all_ones",  ONES, ONES, 120'hFFFFFFFFFFFFFFE000000000000001);
    drive("after_ones", 60'd0, 60'd0, 120'd0);
    drive("p3x5", 60'd3, 60'd5, 120'd15);
    drive("p2_59x2", 60'h800_0000_0000_0000, 60'd2, 120'h1000_0000_0000_0000);
    drive("p34m1x17p1", 60'h3_FFFF_FFFF, 60'h2_0001, 120'h8_0003_FFFD_FFFF);
    drive("p2_17x2_34", 60'h2_0000, 60'h4_0000_0000, 120'h8_0000_0000_0000);
    drive("p34m1x17m1", 60'h3_FFFF_FFFF, 60'h1_FFFF, 120'h7_FFFB_FFFE_0001);
    drive("onesx1", ONES, 60'd1, 120'hFFF_FFFF_FFFF_FFFF);
    drive("zeroxones", 60'd0, ONES, 120'd0);
    drive("p2_34sq", 60'h4_0000_0000, 60'h4_0000_0000, 120'h10_0000_0000_0000_0000);
    drive("onesx2", ONES, 60'd2, 120'h1FFF_FFFF_FFFF_FFFE);
    drive("p17m1sq", 60'h1_FFFF, 60'h1_FFFF, 120'h3_FFFC_0001);
    drive("tail_zero", 60'd0, 60'd0, 120'd0);
    drain();

    // Five issues: first one's result is on C, the next four are still in flight.
    drive("mid0", 60'd7, 60'd9, 120'd63);
    drive("mid1", 60'h100_0000_0000, 60'd3, 120'h300_0000_0000);
    drive("mid2", 60'd100, 60'd100, 120'd10000);
    drive("mid3", 60'h800_0000_0000_0000, 60'h800_0000_0000_0000, 120'h40_0000_0000_0000_0000_0000_0000_0000);
    drive("mid4", ONES, ONES, 120'hFFFFFFFFFFFFFFE000000000000001);
    #1;
    check("pre_reset_c", C, 120'd63);
    rst = 1'b0;
    A = '0;
    B = '0;
    #1;
    check("async_reset_c", C, 120'd0);
    exp_q.delete();
    due_q.delete();
    tag_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("held_reset_c", C, 120'd0);
    rst = 1'b1;

    for (int i = 0; i < LAT + 2; i++) drive("no_stale", 60'd0, 60'd0, 120'd0);
    drive("recover", 60'd11, 60'd13, 120'd143);
    drive("recover_tail", 60'd0, 60'd0, 120'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
